// File: rtl/ram_bus_arbiter_pkg.sv
// Shared constants for the RAM bus arbiter: RAM command codes, bus widths and FSM encodings.
package ram_bus_arbiter_pkg;

  localparam logic RamRead  = 1'b0;
  localparam logic RamWrite = 1'b1;

  localparam int unsigned RamAddrW = 23;
  localparam int unsigned RamDataW = 16;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

endpackage

// File: rtl/ram_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first pending request strictly after last_i, wrapping.
module ram_bus_arbiter_rr_picker #(
  parameter int unsigned NumReq = 3,
  localparam int unsigned IdxW = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   last_i,
  output logic [NumReq-1:0] grant_o,
  output logic [IdxW-1:0]   idx_o
);

  always_comb begin
    int unsigned cand;
    logic [IdxW-1:0] cidx;
    logic found;
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = 0;
    cidx    = '0;
    // Offsets 1..NumReq visit every requester once, ending with last_i itself.
    for (int unsigned k = 1; k <= NumReq; k++) begin
      cand = 32'(last_i) + k;
      if (cand >= NumReq) begin
        cand = cand - NumReq;
      end
      cidx = IdxW'(cand);
      if (!found && req_i[cidx]) begin
        found         = 1'b1;
        idx_o         = cidx;
        grant_o[cidx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_bus_arbiter.sv
// Round-robin sharing of one RAM controller port; one read or write per grant with a watchdog.
module ram_bus_arbiter
  import ram_bus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_write,
  input  logic [RamAddrW*NUM_REQ-1:0]  req_addr,
  input  logic [RamDataW*NUM_REQ-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]           req_ack,
  output logic [NUM_REQ-1:0]           req_err,
  output logic [RamDataW-1:0]          rd_data,
  output logic                         busy,
  output logic [23:1]                  ramBusAddr,
  output logic [RamDataW-1:0]          ramBusDataIn,
  input  logic [RamDataW-1:0]          ramBusDataOut,
  output logic                         ramInstruction,
  output logic                         ramLatch,
  input  logic                         ramReady
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam int unsigned WdW  = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]          state_q, state_d;
  logic [IdxW-1:0]     last_q, last_d;
  logic [IdxW-1:0]     gnt_q, gnt_d;
  logic [IdxW-1:0]     pick_idx;
  logic [NUM_REQ-1:0]  gnt_oh_q, gnt_oh_d;
  logic [NUM_REQ-1:0]  pick_oh;
  logic [NUM_REQ-1:0]  err_q, err_d;
  logic [WdW-1:0]      wd_q, wd_d;
  logic [RamAddrW-1:0] addr_q, addr_d;
  logic [RamDataW-1:0] wdata_q, wdata_d;
  logic [RamDataW-1:0] rdata_q, rdata_d;
  logic                instr_q, instr_d;

  ram_bus_arbiter_rr_picker #(
    .NumReq (NUM_REQ)
  ) u_picker (
    .req_i   (req_valid),
    .last_i  (last_q),
    .grant_o (pick_oh),
    .idx_o   (pick_idx)
  );

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    gnt_oh_d = gnt_oh_q;
    err_d    = '0;
    wd_d     = wd_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    instr_d  = instr_q;

    case (state_q)
      StIdle: begin
        if (|req_valid) begin
          gnt_d    = pick_idx;
          gnt_oh_d = pick_oh;
          for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == IdxW'(i)) begin
              addr_d  = req_addr[i*RamAddrW +: RamAddrW];
              wdata_d = req_wdata[i*RamDataW +: RamDataW];
              instr_d = req_write[i] ? RamWrite : RamRead;
            end
          end
          state_d = StIssue;
        end
      end
      StIssue: begin
        wd_d    = '0;
        state_d = StWait;
      end
      StWait: begin
        // A completion in the expiry cycle still counts as a normal ack.
        if (ramReady) begin
          rdata_d = ramBusDataOut;
          state_d = StDone;
        end else begin
          wd_d = wd_q + WdW'(1);
          if (wd_q == WdW'(TIMEOUT_CYCLES - 1)) begin
            err_d   = gnt_oh_q;
            last_d  = gnt_q;
            state_d = StIdle;
          end
        end
      end
      StDone: begin
        last_d  = gnt_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      last_q   <= IdxW'(NUM_REQ - 1);
      gnt_q    <= '0;
      gnt_oh_q <= '0;
      err_q    <= '0;
      wd_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      instr_q  <= RamRead;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      gnt_oh_q <= gnt_oh_d;
      err_q    <= err_d;
      wd_q     <= wd_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      instr_q  <= instr_d;
    end
  end

  assign req_ack        = (state_q == StDone) ? gnt_oh_q : '0;
  assign req_err        = err_q;
  assign rd_data        = rdata_q;
  assign busy           = (state_q != StIdle);
  assign ramLatch       = (state_q == StIssue);
  assign ramBusAddr     = addr_q;
  assign ramBusDataIn   = wdata_q;
  assign ramInstruction = instr_q;

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Randomized scoreboard bench for ram_bus_arbiter with a round-robin reference model.
module tb_ram_bus_arbiter;

  localparam int NR = 3;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req_valid = '0;
  logic [2:0]  req_write = '0;
  logic [68:0] req_addr = '0;
  logic [47:0] req_wdata = '0;
  logic [2:0]  req_ack;
  logic [2:0]  req_err;
  logic [15:0] rd_data;
  logic        busy;
  logic [23:1] ramBusAddr;
  logic [15:0] ramBusDataIn;
  logic [15:0] ramBusDataOut = '0;
  logic        ramInstruction;
  logic        ramLatch;
  logic        ramReady = 1'b0;

  ram_bus_arbiter #(
    .NUM_REQ        (NR),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_write      (req_write),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_ack        (req_ack),
    .req_err        (req_err),
    .rd_data        (rd_data),
    .busy           (busy),
    .ramBusAddr     (ramBusAddr),
    .ramBusDataIn   (ramBusDataIn),
    .ramBusDataOut  (ramBusDataOut),
    .ramInstruction (ramInstruction),
    .ramLatch       (ramLatch),
    .ramReady       (ramReady)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    int          cyc;
    logic [22:0] addr;
    logic [15:0] wdata;
    logic        wr;
  } grant_t;

  typedef struct {
    bit          timeout;
    int          k;
    logic [15:0] data;
  } resp_t;

  grant_t gq[$];
  resp_t  rq[$];

  int checks = 0;
  int errors = 0;

  // Stimulus controls
  bit          auto_req = 0;
  bit          hold_all = 0;
  bit          force_stray = 0;
  bit          use_fd = 0;
  int          force_k = -1;
  logic [15:0] force_data = '0;
  int          cnt = 0;
  logic [15:0] cur_data = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int pick(input logic [2:0] v, input int last);
    for (int j = 1; j <= NR; j++) begin
      int c;
      c = (last + j) % NR;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // One cycle of requester and RAM-controller behaviour, driven at the falling edge.
  task automatic tick();
    logic [2:0] ack_s, err_s;
    logic       busy_s, latch_s;
    @(negedge clk);
    ack_s   = req_ack;
    err_s   = req_err;
    busy_s  = busy;
    latch_s = ramLatch;

    ramReady      = 1'b0;
    ramBusDataOut = 16'($urandom);
    if (rst) begin
      cnt = 0;
    end else if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        ramReady      = 1'b1;
        ramBusDataOut = cur_data;
      end
    end else if (latch_s) begin
      resp_t r;
      if (force_k >= 0) r.k = force_k;
      else r.k = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, TO));
      r.timeout = (r.k == 0);
      r.data    = use_fd ? force_data : 16'($urandom);
      cur_data  = r.data;
      cnt       = r.k;
      rq.push_back(r);
    end
    if (force_stray ||
        (auto_req && cnt == 0 && (!busy_s || ack_s != 0) && $urandom_range(0, 7) == 0)) begin
      ramReady = 1'b1;
    end

    for (int i = 0; i < NR; i++) begin
      if (req_valid[i] && (ack_s[i] || err_s[i]) && !hold_all) begin
        req_valid[i] = auto_req ? 1'($urandom_range(0, 1)) : 1'b0;
      end else if (!req_valid[i] && auto_req && $urandom_range(0, 2) == 0) begin
        req_valid[i] = 1'b1;
      end
      if (auto_req && (busy_s || !req_valid[i])) begin
        req_addr[i*23 +: 23]  = 23'($urandom);
        req_wdata[i*16 +: 16] = 16'($urandom);
        req_write[i]          = 1'($urandom_range(0, 1));
      end
    end
  endtask

  // Monitor: reference arbitration model plus scoreboard, sampled 1 time unit after each edge.
  initial begin
    int          cyc;
    int          model_last;
    logic [15:0] model_rd;
    bit          prev_idle;
    bit          prev_latch;
    grant_t      g;
    resp_t       r;
    logic [2:0]  mask;
    int          e;
    cyc        = 0;
    model_last = NR - 1;
    model_rd   = '0;
    prev_idle  = 0;
    prev_latch = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst) begin
        chk("reset_outputs", {ramBusAddr, ramBusDataIn, ramInstruction, ramLatch, req_ack,
                              req_err, rd_data, busy}, 64'd0);
        gq.delete();
        rq.delete();
        model_last = NR - 1;
        model_rd   = '0;
        prev_idle  = 0;
        prev_latch = 0;
        continue;
      end
      if (prev_idle) chk("grant_when_pending", ramLatch, |req_valid);
      if (ramLatch) begin
        chk("latch_single_cycle", prev_latch, 0);
        chk("issue_busy", busy, 1);
        e = pick(req_valid, model_last);
        if (e < 0) begin
          checks++;
          errors++;
          $display("FAIL latch_without_request actual=1 required=0");
        end else begin
          g.idx   = e;
          g.cyc   = cyc;
          g.addr  = req_addr[e*23 +: 23];
          g.wdata = req_wdata[e*16 +: 16];
          g.wr    = req_write[e];
          gq.push_back(g);
          chk("issue_addr", ramBusAddr, g.addr);
          chk("issue_wdata", ramBusDataIn, g.wdata);
          chk("issue_instr", ramInstruction, g.wr);
        end
      end
      if ((req_ack | req_err) != 0) begin
        if (gq.size() == 0 || rq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual ack=%b err=%b required none", req_ack, req_err);
        end else begin
          g    = gq.pop_front();
          r    = rq.pop_front();
          mask = 3'b001 << g.idx;
          if (r.timeout) begin
            chk("err_vector", req_err, mask);
            chk("err_no_ack", req_ack, 0);
            chk("err_latency", cyc - g.cyc, TO + 1);
          end else begin
            chk("ack_vector", req_ack, mask);
            chk("ack_no_err", req_err, 0);
            chk("ack_latency", cyc - g.cyc, r.k + 1);
            chk("ack_rd_data", rd_data, r.data);
            model_rd = r.data;
          end
          chk("hold_addr", ramBusAddr, g.addr);
          chk("hold_wdata", ramBusDataIn, g.wdata);
          chk("hold_instr", ramInstruction, g.wr);
          model_last = g.idx;
        end
      end
      if (!busy) chk("idle_rd_data", rd_data, model_rd);
      prev_idle  = !busy;
      prev_latch = ramLatch;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    repeat (3) tick();
    rst = 1'b0;

    // Single read from requester 0, RAM answers 3 cycles after the latch.
    req_addr[22:0] = 23'h000010;
    req_write[0]   = 1'b0;
    req_valid      = 3'b001;
    force_k        = 3;
    use_fd         = 1;
    force_data     = 16'hBEEF;
    repeat (10) tick();

    // Single write from requester 1 at the top address.
    req_addr[45:23]  = 23'h7FFFFF;
    req_wdata[31:16] = 16'h1234;
    req_write[1]     = 1'b1;
    req_valid        = 3'b010;
    force_k          = 1;
    force_data       = 16'h5A5A;
    repeat (8) tick();

    // Fairness: everyone held high, one-cycle RAM.
    use_fd    = 0;
    hold_all  = 1;
    req_valid = 3'b111;
    repeat (25) tick();
    hold_all = 0;
    repeat (14) tick();

    // Timeouts on two requesters in turn.
    force_k   = 0;
    req_valid = 3'b011;
    repeat (24) tick();

    // Reset in the middle of WAIT, with ramReady arriving during and after reset.
    req_valid = 3'b111;
    for (int i = 0; i < 20 && !(busy && !ramLatch); i++) tick();
    repeat (2) tick();
    rst = 1'b1;
    tick();
    force_stray = 1;
    tick();
    rst = 1'b0;
    tick();
    force_stray = 0;
    force_k     = 2;
    repeat (24) tick();

    // Stray ramReady while idle.
    req_valid   = 3'b000;
    force_stray = 1;
    repeat (3) tick();
    force_stray = 0;
    tick();

    // Random traffic.
    auto_req = 1;
    force_k  = -1;
    repeat (1500) tick();

    // Drain with a bounded wait.
    auto_req = 0;
    for (int i = 0; i < 120 && (busy || req_valid != 0 || gq.size() != 0); i++) tick();
    repeat (2) tick();
    chk("drain_idle", busy, 0);
    chk("drain_grants", gq.size(), 0);
    chk("drain_resps", rq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
